uart_tx_arbiter: RTL

- Shares one uart_tx transmitter between N_REQ byte requesters using round-robin arbitration.
- Sequences the transmitter's send/ready handshake: latches the winning byte, pulses send, tracks the frame until ready returns, then reports completion to the owner.
- Sits between client logic (command responders, status reporters) and the uart_tx/baudRGen pair.
- Frame format (data_size, parity, stop bits) is configured directly on uart_tx and is outside this block.

---
 rtl/uart_tx_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among N_REQ byte requesters
// Grants a byte, holds tx_send until uart_tx drops ready, then reports done to the owner.
module uart_tx_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ID_W      = 2,
   parameter int LAUNCH_TO = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     ack,
   output logic [N_REQ-1:0]     done,
   output logic                 timeout,
   output logic                 busy,
   output logic [ID_W-1:0]      cur_id,
   output logic                 tx_send,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready
);
   localparam int CNT_W = $clog2(LAUNCH_TO) + 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

   state_t           state;
   logic [ID_W-1:0]  last;
   logic [CNT_W-1:0] cnt;
   logic             grant_valid;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W-1:0]  scan_idx;

   function automatic logic [ID_W-1:0] wrap_idx(input int v);
      return ID_W'(v % N_REQ);
   endfunction

   // Scan starts just after the previous owner so every pending requester is served once per lap.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      scan_idx    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         scan_idx = wrap_idx(int'(last) + k);
         if (!grant_valid && req[scan_idx]) begin
            grant_valid = 1'b1;
            grant_id    = scan_idx;
         end
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         last    <= ID_W'(N_REQ - 1);
         cnt     <= '0;
         ack     <= '0;
         done    <= '0;
         timeout <= 1'b0;
         cur_id  <= '0;
         tx_send <= 1'b0;
         tx_data <= '0;
      end else begin
         ack     <= '0;
         done    <= '0;
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_ready && grant_valid) begin
                  tx_data <= req_data[{grant_id, 3'b000} +: 8];
                  cur_id  <= grant_id;
                  last    <= grant_id;
                  cnt     <= '0;
                  ack     <= N_REQ'(1) << grant_id;
                  tx_send <= 1'b1;
                  state   <= LAUNCH;
               end
            end
            LAUNCH: begin
               // send is held because uart_tx only samples it on its baud enable
               cnt <= cnt + 1'b1;
               if (!tx_ready) begin
                  tx_send <= 1'b0;
                  state   <= BUSY;
               end else if (cnt == CNT_W'(LAUNCH_TO - 1)) begin
                  tx_send <= 1'b0;
                  timeout <= 1'b1;
                  state   <= IDLE;
               end
            end
            BUSY: begin
               if (tx_ready) begin
                  done  <= N_REQ'(1) << cur_id;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
